mem_bus_arbiter: RTL and testbench

- Shares the single Wishbone B4 classic master port between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Sequences each bus cycle, arbitrates simultaneous requests and enforces a bus timeout.
- Returns the data and error for each cycle to the requester that issued it.
- Drives MEM_BUSY and MEM_DONE, which feed the hazard unit's WISHBONE_REQ/WISHBONE_DONE stall inputs.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_bus_timeout_counter.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default sizing for the fetch/load-store Wishbone arbiter.
// Imported by the arbiter top and its timeout counter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF_CYC,
    ARB_MEM_CYC
  } arb_state_t;

  typedef enum logic {
    GRANT_IF,
    GRANT_MEM
  } arb_grant_t;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_bus_arbiter_bus_timeout_counter.sv
// Counts bus-cycle clocks without a termination; expired flags the clock whose
// increment would reach TIMEOUT_CYCLES, so the FSM ends the cycle on that edge.
module bus_timeout_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // With CYC high for TIMEOUT_CYCLES clocks and no ACK/ERR, CYC drops on the
  // edge that brings the count to TIMEOUT_CYCLES.
  assign expired = en & (count == LAST_CNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone B4 classic master port between instruction fetch and the
// MEM stage: arbitration, cycle sequencing, timeout and response routing.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IF_REQ,
  input  logic [ADDR_WIDTH-1:0]   IF_ADDR,
  input  logic                    IF_FLUSH,
  output logic                    IF_DONE,
  output logic [DATA_WIDTH-1:0]   IF_RDATA,
  output logic                    IF_ERR,
  input  logic                    MEM_REQ,
  input  logic                    MEM_WE,
  input  logic [ADDR_WIDTH-1:0]   MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]   MEM_WDATA,
  input  logic [DATA_WIDTH/8-1:0] MEM_SEL,
  output logic                    MEM_DONE,
  output logic [DATA_WIDTH-1:0]   MEM_RDATA,
  output logic                    MEM_ERR,
  output logic                    MEM_BUSY,
  output logic                    WB_CYC_O,
  output logic                    WB_STB_O,
  output logic                    WB_WE_O,
  output logic [ADDR_WIDTH-1:0]   WB_ADR_O,
  output logic [DATA_WIDTH-1:0]   WB_DAT_O,
  output logic [DATA_WIDTH/8-1:0] WB_SEL_O,
  input  logic [DATA_WIDTH-1:0]   WB_DAT_I,
  input  logic                    WB_ACK_I,
  input  logic                    WB_ERR_I
);

  // state       | meaning
  // ARB_IDLE    | bus free, arbitrating between IF and MEM requests
  // ARB_IF_CYC  | fetch read cycle on the bus
  // ARB_MEM_CYC | load/store cycle on the bus
  arb_state_t state;
  arb_grant_t last_grant;
  logic       discard;

  logic                  in_cyc;
  logic                  if_req_eff;
  logic                  mem_req_eff;
  logic                  grant_mem;
  logic                  grant_if;
  logic                  bus_term;
  logic                  timed_out;
  logic                  finish;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  to_clear;
  logic                  to_en;

  assign in_cyc = (state != ARB_IDLE);

  // A requester whose DONE is high this cycle is still showing its old level
  // request, so it is masked out to avoid reissuing a completed access.
  assign if_req_eff  = IF_REQ & ~IF_DONE & ~IF_FLUSH;
  assign mem_req_eff = MEM_REQ & ~MEM_DONE;

  assign grant_mem = mem_req_eff & (~if_req_eff | (last_grant == GRANT_IF));
  assign grant_if  = if_req_eff & ~grant_mem;

  assign bus_term  = WB_ACK_I | WB_ERR_I;
  assign finish    = in_cyc & (bus_term | timed_out);
  assign resp_err  = WB_ERR_I | ~bus_term;
  assign resp_data = bus_term ? WB_DAT_I : '0;

  assign to_clear = ~in_cyc;
  assign to_en    = in_cyc & ~bus_term;

  // Gated with reset so the stall request is also low while the block is held in reset.
  assign MEM_BUSY = RST_N & MEM_REQ & ~MEM_DONE;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (to_clear),
    .en     (to_en),
    .expired(timed_out)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_IF;
      discard    <= 1'b0;
      WB_CYC_O   <= 1'b0;
      WB_STB_O   <= 1'b0;
      WB_WE_O    <= 1'b0;
      WB_ADR_O   <= '0;
      WB_DAT_O   <= '0;
      WB_SEL_O   <= '0;
      IF_DONE    <= 1'b0;
      IF_ERR     <= 1'b0;
      IF_RDATA   <= '0;
      MEM_DONE   <= 1'b0;
      MEM_ERR    <= 1'b0;
      MEM_RDATA  <= '0;
    end else begin
      IF_DONE   <= 1'b0;
      IF_ERR    <= 1'b0;
      IF_RDATA  <= '0;
      MEM_DONE  <= 1'b0;
      MEM_ERR   <= 1'b0;
      MEM_RDATA <= '0;

      case (state)
        ARB_IDLE: begin
          discard <= 1'b0;
          if (grant_mem) begin
            state      <= ARB_MEM_CYC;
            last_grant <= GRANT_MEM;
            WB_CYC_O   <= 1'b1;
            WB_STB_O   <= 1'b1;
            WB_WE_O    <= MEM_WE;
            WB_ADR_O   <= MEM_ADDR;
            WB_DAT_O   <= MEM_WDATA;
            WB_SEL_O   <= MEM_SEL;
          end else if (grant_if) begin
            state      <= ARB_IF_CYC;
            last_grant <= GRANT_IF;
            WB_CYC_O   <= 1'b1;
            WB_STB_O   <= 1'b1;
            WB_WE_O    <= 1'b0;
            WB_ADR_O   <= IF_ADDR;
            WB_DAT_O   <= '0;
            WB_SEL_O   <= '1;
          end
        end

        ARB_IF_CYC: begin
          if (IF_FLUSH) begin
            discard <= 1'b1;
          end
          if (finish) begin
            state    <= ARB_IDLE;
            discard  <= 1'b0;
            WB_CYC_O <= 1'b0;
            WB_STB_O <= 1'b0;
            WB_WE_O  <= 1'b0;
            WB_ADR_O <= '0;
            WB_DAT_O <= '0;
            WB_SEL_O <= '0;
            // A flush that lands on the terminating clock also drops the response.
            if (!(discard || IF_FLUSH)) begin
              IF_DONE  <= 1'b1;
              IF_ERR   <= resp_err;
              IF_RDATA <= resp_data;
            end
          end
        end

        ARB_MEM_CYC: begin
          if (finish) begin
            state     <= ARB_IDLE;
            WB_CYC_O  <= 1'b0;
            WB_STB_O  <= 1'b0;
            WB_WE_O   <= 1'b0;
            WB_ADR_O  <= '0;
            WB_DAT_O  <= '0;
            WB_SEL_O  <= '0;
            MEM_DONE  <= 1'b1;
            MEM_ERR   <= resp_err;
            MEM_RDATA <= resp_data;
          end
        end

        default: begin
          state    <= ARB_IDLE;
          WB_CYC_O <= 1'b0;
          WB_STB_O <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle vector table followed by
// hand-written sequences for alternation, timeout, flush and async reset.
module tb_mem_bus_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic        IF_FLUSH;
  logic        IF_DONE;
  logic [31:0] IF_RDATA;
  logic        IF_ERR;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_SEL;
  logic        MEM_DONE;
  logic [31:0] MEM_RDATA;
  logic        MEM_ERR;
  logic        MEM_BUSY;
  logic        WB_CYC_O;
  logic        WB_STB_O;
  logic        WB_WE_O;
  logic [31:0] WB_ADR_O;
  logic [31:0] WB_DAT_O;
  logic [3:0]  WB_SEL_O;
  logic [31:0] WB_DAT_I;
  logic        WB_ACK_I;
  logic        WB_ERR_I;

  mem_bus_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IF_REQ   (IF_REQ),
    .IF_ADDR  (IF_ADDR),
    .IF_FLUSH (IF_FLUSH),
    .IF_DONE  (IF_DONE),
    .IF_RDATA (IF_RDATA),
    .IF_ERR   (IF_ERR),
    .MEM_REQ  (MEM_REQ),
    .MEM_WE   (MEM_WE),
    .MEM_ADDR (MEM_ADDR),
    .MEM_WDATA(MEM_WDATA),
    .MEM_SEL  (MEM_SEL),
    .MEM_DONE (MEM_DONE),
    .MEM_RDATA(MEM_RDATA),
    .MEM_ERR  (MEM_ERR),
    .MEM_BUSY (MEM_BUSY),
    .WB_CYC_O (WB_CYC_O),
    .WB_STB_O (WB_STB_O),
    .WB_WE_O  (WB_WE_O),
    .WB_ADR_O (WB_ADR_O),
    .WB_DAT_O (WB_DAT_O),
    .WB_SEL_O (WB_SEL_O),
    .WB_DAT_I (WB_DAT_I),
    .WB_ACK_I (WB_ACK_I),
    .WB_ERR_I (WB_ERR_I)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [139:0] outs;
  assign outs = {WB_CYC_O, WB_STB_O, WB_WE_O, WB_ADR_O, WB_DAT_O, WB_SEL_O,
                 MEM_DONE, MEM_ERR, MEM_BUSY, MEM_RDATA, IF_DONE, IF_ERR, IF_RDATA};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic mem_req; logic mem_we; logic [31:0] mem_addr; logic [31:0] mem_wdata; logic [3:0] mem_sel;
    logic if_req; logic [31:0] if_addr; logic if_flush;
    logic ack; logic err; logic [31:0] dat_i;
    logic e_cyc; logic e_we; logic [31:0] e_adr; logic [31:0] e_dat; logic [3:0] e_sel;
    logic e_mdone; logic e_merr; logic e_mbusy; logic [31:0] e_mrdata;
    logic e_idone; logic e_ierr; logic [31:0] e_irdata;
  } vec_t;

  vec_t vq[$];

  task automatic wait_cyc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge CLK); #1;
      if (WB_CYC_O) ok = 1'b1;
    end
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    bit          ok;
    bit          seen;
    int          n;
    int          cc;
    int          ng;
    logic [31:0] grants [4];
    logic [31:0] exp_g  [4];
    logic [139:0] ev;

    RST_N = 1'b0; IF_REQ = 1'b0; IF_ADDR = Z; IF_FLUSH = 1'b0;
    MEM_REQ = 1'b0; MEM_WE = 1'b0; MEM_ADDR = Z; MEM_WDATA = Z; MEM_SEL = 4'h0;
    WB_DAT_I = Z; WB_ACK_I = 1'b0; WB_ERR_I = 1'b0;

    // mreq mwe maddr mwdata msel | ifreq ifaddr flush | ack err dat_i || cyc we adr dat sel | mdone merr mbusy mrdata | idone ierr irdata
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b0,Z,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b0,32'h100,Z,4'hf, 1'b0,Z,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b1,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b0,32'h100,Z,4'hf, 1'b0,Z,1'b0, 1'b1,1'b0,32'hDEADBEEF, 1'b1,1'b0,32'h100,Z,4'hf, 1'b0,1'b0,1'b1,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b0,32'h100,Z,4'hf, 1'b0,Z,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b1,1'b0,1'b0,32'hDEADBEEF, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b0,Z,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b1,32'h400,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b1,32'h400,1'b0, 1'b1,1'b1,32'hCAFEF00D, 1'b1,1'b0,32'h400,Z,4'hf, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b0,Z,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b0,Z, 1'b1,1'b1,32'hCAFEF00D});
    vq.push_back(vec_t'{1'b1,1'b1,32'h2004,32'h12345678,4'h3, 1'b1,32'h800,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b1,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b1,32'h3000,32'hFFFFFFFF,4'hc, 1'b1,32'h800,1'b0, 1'b0,1'b0,Z, 1'b1,1'b1,32'h2004,32'h12345678,4'h3, 1'b0,1'b0,1'b1,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b1,32'h3000,32'hFFFFFFFF,4'hc, 1'b1,32'h800,1'b0, 1'b0,1'b0,Z, 1'b1,1'b1,32'h2004,32'h12345678,4'h3, 1'b0,1'b0,1'b1,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b1,32'h3000,32'hFFFFFFFF,4'hc, 1'b1,32'h800,1'b0, 1'b1,1'b0,32'h55555555, 1'b1,1'b1,32'h2004,32'h12345678,4'h3, 1'b0,1'b0,1'b1,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b1,32'h3000,32'hFFFFFFFF,4'hc, 1'b1,32'h800,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b1,1'b0,1'b0,32'h55555555, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b1,32'h3000,32'hFFFFFFFF,4'hc, 1'b1,32'h800,1'b0, 1'b1,1'b0,32'h11112222, 1'b1,1'b0,32'h800,Z,4'hf, 1'b0,1'b0,1'b1,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b1,1'b1,32'h3000,32'hFFFFFFFF,4'hc, 1'b1,32'h800,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b1,Z, 1'b1,1'b0,32'h11112222});
    vq.push_back(vec_t'{1'b1,1'b1,32'h3000,32'hFFFFFFFF,4'hc, 1'b0,Z,1'b0, 1'b0,1'b1,32'h9999AAAA, 1'b1,1'b1,32'h3000,32'hFFFFFFFF,4'hc, 1'b0,1'b0,1'b1,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b0,Z,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b1,1'b1,1'b0,32'h9999AAAA, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b0,Z,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b1,32'hA00,1'b1, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b1,32'hA00,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b1,32'hA00,1'b0, 1'b1,1'b0,32'h00000077, 1'b1,1'b0,32'hA00,Z,4'hf, 1'b0,1'b0,1'b0,Z, 1'b0,1'b0,Z});
    vq.push_back(vec_t'{1'b0,1'b0,Z,Z,4'h0, 1'b0,Z,1'b0, 1'b0,1'b0,Z, 1'b0,1'b0,Z,Z,4'h0, 1'b0,1'b0,1'b0,Z, 1'b1,1'b0,32'h00000077});

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state", outs, '0);
    RST_N = 1'b1;

    foreach (vq[i]) begin
      @(posedge CLK); #1;
      MEM_REQ = vq[i].mem_req; MEM_WE = vq[i].mem_we; MEM_ADDR = vq[i].mem_addr;
      MEM_WDATA = vq[i].mem_wdata; MEM_SEL = vq[i].mem_sel;
      IF_REQ = vq[i].if_req; IF_ADDR = vq[i].if_addr; IF_FLUSH = vq[i].if_flush;
      WB_ACK_I = vq[i].ack; WB_ERR_I = vq[i].err; WB_DAT_I = vq[i].dat_i;
      @(negedge CLK);
      ev = {vq[i].e_cyc, vq[i].e_cyc, vq[i].e_we, vq[i].e_adr, vq[i].e_dat, vq[i].e_sel,
            vq[i].e_mdone, vq[i].e_merr, vq[i].e_mbusy, vq[i].e_mrdata,
            vq[i].e_idone, vq[i].e_ierr, vq[i].e_irdata};
      chk($sformatf("vec%0d", i), outs, ev);
    end

    // Both requesters held high with a one-wait-state slave: grants must alternate.
    @(posedge CLK); #1;
    IF_ADDR = 32'h1000; MEM_ADDR = 32'h2000; MEM_WE = 1'b0; MEM_SEL = 4'hf; MEM_WDATA = Z;
    IF_REQ = 1'b1; MEM_REQ = 1'b1; WB_DAT_I = Z;
    cc = 0; ng = 0;
    for (int k = 0; k < 4; k++) grants[k] = Z;
    exp_g[0] = 32'h2000; exp_g[1] = 32'h1000; exp_g[2] = 32'h2000; exp_g[3] = 32'h1000;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (WB_CYC_O) cc++; else cc = 0;
      if (WB_CYC_O && cc == 1 && ng < 4) begin
        grants[ng] = WB_ADR_O;
        ng++;
        if (ng == 4) begin IF_REQ = 1'b0; MEM_REQ = 1'b0; end
      end
      WB_ACK_I = (cc == 2);
    end
    WB_ACK_I = 1'b0;
    for (int k = 0; k < 4; k++) chk($sformatf("alt_grant%0d", k), grants[k], exp_g[k]);

    // Silent slave: CYC must stay up exactly 8 clocks, then an error response with zero data.
    @(posedge CLK); #1;
    MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_ADDR = 32'h40; MEM_SEL = 4'hf; WB_DAT_I = 32'hBAD0BAD0;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge CLK); #1;
      if (WB_CYC_O) n++;
      else if (n > 0) seen = 1'b1;
    end
    chk("timeout_len", n, 8);
    chk("timeout_resp", {MEM_DONE, MEM_ERR, MEM_RDATA}, {1'b1, 1'b1, 32'h0});
    MEM_REQ = 1'b0;
    @(posedge CLK); #1;
    MEM_REQ = 1'b1; MEM_ADDR = 32'h44;
    wait_cyc(ok);
    chk("timeout_regrant", {ok, WB_ADR_O}, {1'b1, 32'h44});
    WB_ACK_I = 1'b1; WB_DAT_I = 32'h44444444;
    @(posedge CLK); #1;
    WB_ACK_I = 1'b0; MEM_REQ = 1'b0;
    chk("timeout_next_done", {MEM_DONE, MEM_ERR, MEM_RDATA}, {1'b1, 1'b0, 32'h44444444});

    // Flush during a fetch: cycle completes on the bus but IF_DONE stays low.
    @(posedge CLK); #1;
    IF_REQ = 1'b1; IF_ADDR = 32'h500;
    wait_cyc(ok);
    chk("flush_grant", {ok, WB_ADR_O}, {1'b1, 32'h500});
    IF_FLUSH = 1'b1;
    seen = 1'b0;
    @(posedge CLK); #1;
    seen |= IF_DONE; IF_FLUSH = 1'b0; IF_ADDR = 32'h600;
    @(posedge CLK); #1;
    seen |= IF_DONE;
    chk("flush_adr_hold", {WB_CYC_O, WB_ADR_O}, {1'b1, 32'h500});
    @(posedge CLK); #1;
    seen |= IF_DONE; WB_ACK_I = 1'b1; WB_DAT_I = 32'h5A5A5A5A;
    @(posedge CLK); #1;
    seen |= IF_DONE; WB_ACK_I = 1'b0;
    chk("flush_cyc_end", WB_CYC_O, 1'b0);
    chk("flush_no_done", seen, 1'b0);
    wait_cyc(ok);
    chk("flush_fresh_grant", {ok, WB_ADR_O}, {1'b1, 32'h600});
    WB_ACK_I = 1'b1; WB_DAT_I = 32'h00600600;
    @(posedge CLK); #1;
    WB_ACK_I = 1'b0; IF_REQ = 1'b0;
    chk("flush_fresh_done", {IF_DONE, IF_ERR, IF_RDATA}, {1'b1, 1'b0, 32'h00600600});

    // Asynchronous reset in the middle of a MEM cycle.
    @(posedge CLK); #1;
    MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_ADDR = 32'h700; MEM_SEL = 4'hf;
    wait_cyc(ok);
    chk("rst_grant", ok, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_async_outputs", outs, '0);
    @(posedge CLK); #2;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst_release_grant", {WB_CYC_O, MEM_DONE, WB_ADR_O}, {1'b1, 1'b0, 32'h700});
    WB_ACK_I = 1'b1; WB_DAT_I = 32'hABCD0123;
    @(posedge CLK); #1;
    WB_ACK_I = 1'b0; MEM_REQ = 1'b0;
    chk("rst_release_done", {MEM_DONE, MEM_ERR, MEM_RDATA}, {1'b1, 1'b0, 32'hABCD0123});

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
